// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the seq_div restoring divider.
// The optional macro SEQ_DIV_ZERO_FAST_EN is consumed by seq_div.sv, not here.
package seq_div_pkg;

    localparam int DEF_WIDTH = 64;
    localparam int MAX_W     = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Operands are zero-extended to MAX_W; callers truncate back to their width.
    function automatic logic [MAX_W-1:0] cond_neg(input logic neg, input logic [MAX_W-1:0] v);
        return neg ? (~v + MAX_W'(1)) : v;
    endfunction

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module seq_div_step #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH:0]   i_p,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH:0]   o_p,
    output logic             o_qbit
);

    logic [WIDTH+1:0] w_sh;
    logic [WIDTH+1:0] w_diff;

    // The partial remainder stays below the divisor, so the top bit of w_sh is always 0
    // and the sign of w_diff is a reliable borrow.
    assign w_sh   = {i_p, i_bit};
    assign w_diff = w_sh - (WIDTH+2)'(i_dvs);
    assign o_qbit = ~w_diff[WIDTH+1];
    assign o_p    = o_qbit ? w_diff[WIDTH:0] : w_sh[WIDTH:0];

endmodule

// File: rtl/seq_div.sv
// Sequential radix-2 restoring divider with RISC-V DIV/DIVU/REM/REMU semantics.
// Define SEQ_DIV_ZERO_FAST_EN to let a zero divisor bypass the CALC phase.
module seq_div
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             L,
    input  logic             sgn,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_zero;
    logic             r_qneg;
    logic             r_rneg;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH:0]   r_p;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;

    logic [WIDTH:0]   w_p_nxt;
    logic             w_qbit;
    logic             w_zero_in;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    assign w_zero_in = (divisor == '0);
    assign w_dvd_mag = WIDTH'(cond_neg(sgn & dividend[WIDTH-1], MAX_W'(dividend)));
    assign w_dvs_mag = WIDTH'(cond_neg(sgn & divisor[WIDTH-1], MAX_W'(divisor)));

    // A zero divisor leaves the dividend magnitude in r_p, so re-signing it restores the dividend.
    assign w_quo_fix = r_zero ? '1 : WIDTH'(cond_neg(r_qneg, MAX_W'(r_a)));
    assign w_rem_fix = WIDTH'(cond_neg(r_rneg, MAX_W'(r_p[WIDTH-1:0])));

    seq_div_step #(.WIDTH(WIDTH)) u_step (
        .i_p    (r_p),
        .i_bit  (r_a[WIDTH-1]),
        .i_dvs  (r_b),
        .o_p    (w_p_nxt),
        .o_qbit (w_qbit)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_zero  <= 1'b0;
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_p     <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (L) begin
                        r_zero  <= w_zero_in;
                        r_qneg  <= sgn & (dividend[WIDTH-1] ^ divisor[WIDTH-1]) & ~w_zero_in;
                        r_rneg  <= sgn & dividend[WIDTH-1];
                        r_a     <= w_dvd_mag;
                        r_b     <= w_dvs_mag;
                        r_p     <= '0;
                        r_cnt   <= CNT_W'(WIDTH);
                        r_state <= ST_CALC;
`ifdef SEQ_DIV_ZERO_FAST_EN
                        if (w_zero_in) begin
                            r_p     <= {1'b0, w_dvd_mag};
                            r_state <= ST_FIX;
                        end
`endif
                    end
                end
                ST_CALC: begin
                    r_p   <= w_p_nxt;
                    r_a   <= {r_a[WIDTH-2:0], w_qbit};
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_quo   <= w_quo_fix;
                    r_rem   <= w_rem_fix;
                    r_state <= ST_DONE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign quotient  = r_quo;
    assign remainder = r_rem;
    assign busy      = (r_state == ST_CALC) || (r_state == ST_FIX);
    assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div (WIDTH=64) against a plain-arithmetic division model.
module tb_seq_div;

    localparam int W    = 64;
    localparam int LAT  = W + 1;
`ifdef SEQ_DIV_ZERO_FAST_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = W + 1;
`endif

    logic         Clk = 1'b0;
    logic         Rst;
    logic         L;
    logic         sgn;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;

    seq_div #(.WIDTH(W)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .L         (L),
        .sgn       (sgn),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done)
    );

    always #5 Clk = ~Clk;

    function automatic void model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa, sb;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (s) begin
            sa = a;
            sb = b;
            if (a == 64'h8000_0000_0000_0000 && b == '1) begin
                q = a;
                r = '0;
            end else begin
                q = sa / sb;
                r = sa % sb;
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int bcnt);
        sgn = s; dividend = a; divisor = b; L = 1'b1;
        @(posedge Clk); #1;
        L = 1'b0;
        dividend = {$urandom, $urandom};
        divisor  = {$urandom, $urandom};
        sgn      = ~s;
        lat = 0; bcnt = 0;
        while (!done && lat < 200) begin
            if (busy) bcnt++;
            @(posedge Clk); #1;
            lat++;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL timeout: done never rose within %0d cycles", lat);
        end
    endtask

    task automatic test_reset();
        Rst = 1'b0; L = 1'b0; sgn = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge Clk);
        #1;
        total++; if (quotient !== '0)  begin bad++; $display("FAIL reset_q: got %h want 0", quotient); end
        total++; if (remainder !== '0) begin bad++; $display("FAIL reset_r: got %h want 0", remainder); end
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0)    begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        Rst = 1'b1;
        @(posedge Clk); #1;
    endtask

    task automatic test_unsigned();
        int lat, bcnt;
        logic [W-1:0] a, b, eq, er;
        run_op(1'b0, 64'd120, 64'd29, lat, bcnt);
        total++; if (quotient !== 64'd4)  begin bad++; $display("FAIL u_q: got %0d want 4", quotient); end
        total++; if (remainder !== 64'd4) begin bad++; $display("FAIL u_r: got %0d want 4", remainder); end
        total++; if (lat !== LAT)         begin bad++; $display("FAIL u_latency: got %0d want %0d", lat, LAT); end
        total++; if (bcnt !== LAT)        begin bad++; $display("FAIL u_busy_cycles: got %0d want %0d", bcnt, LAT); end
        for (int i = 0; i < 8; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom} >> $urandom_range(0, 62);
            if (i == 0) b = 64'h8000_0000_0000_0000;
            if (b == '0) b = 64'd3;
            model(1'b0, a, b, eq, er);
            run_op(1'b0, a, b, lat, bcnt);
            total++; if (quotient !== eq)  begin bad++; $display("FAIL u_rand_q: %h/%h got %h want %h", a, b, quotient, eq); end
            total++; if (remainder !== er) begin bad++; $display("FAIL u_rand_r: %h/%h got %h want %h", a, b, remainder, er); end
        end
    endtask

    task automatic test_back_to_back();
        int lat, bcnt;
        run_op(1'b0, 64'd3480, 64'd29, lat, bcnt);
        total++; if (quotient !== 64'd120) begin bad++; $display("FAIL b2b_q1: got %0d want 120", quotient); end
        total++; if (remainder !== 64'd0)  begin bad++; $display("FAIL b2b_r1: got %0d want 0", remainder); end
        sgn = 1'b0; dividend = 64'd84; divisor = 64'd30; L = 1'b1;
        @(posedge Clk); #1;
        L = 1'b0;
        total++; if (done !== 1'b0)        begin bad++; $display("FAIL b2b_done_drop: got %b want 0", done); end
        total++; if (quotient !== 64'd120) begin bad++; $display("FAIL b2b_held_q: got %0d want 120", quotient); end
        repeat (W - 1) @(posedge Clk);
        #1;
        total++; if (remainder !== 64'd0)  begin bad++; $display("FAIL b2b_held_r_late: got %0d want 0", remainder); end
        lat = 0;
        while (!done && lat < 10) begin @(posedge Clk); #1; lat++; end
        total++; if (lat !== 2)            begin bad++; $display("FAIL b2b_latency_tail: got %0d want 2", lat); end
        total++; if (quotient !== 64'd2)   begin bad++; $display("FAIL b2b_q2: got %0d want 2", quotient); end
        total++; if (remainder !== 64'd24) begin bad++; $display("FAIL b2b_r2: got %0d want 24", remainder); end
    endtask

    task automatic test_hold_load();
        int n;
        sgn = 1'b0; dividend = 64'd5; divisor = 64'd2; L = 1'b1;
        n = 0;
        @(posedge Clk); #1;
        while (!done && n < 200) begin @(posedge Clk); #1; n++; end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL hold_first_done: got %b want 1", done); end
        @(posedge Clk); #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL hold_restart_done: got %b want 0", done); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL hold_restart_busy: got %b want 1", busy); end
        L = 1'b0;
        n = 0;
        while (!done && n < 200) begin @(posedge Clk); #1; n++; end
        total++; if (quotient !== 64'd2)  begin bad++; $display("FAIL hold_q: got %0d want 2", quotient); end
        total++; if (remainder !== 64'd1) begin bad++; $display("FAIL hold_r: got %0d want 1", remainder); end
    endtask

    task automatic test_signed();
        int lat, bcnt;
        logic s;
        logic [W-1:0] a, b, eq, er;
        run_op(1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, lat, bcnt);
        total++; if (quotient !== 64'hFFFF_FFFF_FFFF_FFFD)  begin bad++; $display("FAIL s_q: got %h want fffffffffffffffd", quotient); end
        total++; if (remainder !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL s_r: got %h want ffffffffffffffff", remainder); end
        run_op(1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, lat, bcnt);
        total++; if (quotient !== 64'h7FFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL su_q: got %h want 7ffffffffffffffc", quotient); end
        total++; if (remainder !== 64'd1)                  begin bad++; $display("FAIL su_r: got %h want 1", remainder); end
        for (int i = 0; i < 10; i++) begin
            s = 1'($urandom_range(0, 1));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom} >> $urandom_range(1, 62);
            if (b == '0) b = 64'd5;
            if ($urandom_range(0, 1) == 1) b = -b;
            model(s, a, b, eq, er);
            run_op(s, a, b, lat, bcnt);
            total++; if (quotient !== eq)  begin bad++; $display("FAIL s_rand_q: sgn=%b %h/%h got %h want %h", s, a, b, quotient, eq); end
            total++; if (remainder !== er) begin bad++; $display("FAIL s_rand_r: sgn=%b %h/%h got %h want %h", s, a, b, remainder, er); end
        end
    endtask

    task automatic test_div_zero();
        int lat, bcnt;
        for (int s = 0; s < 2; s++) begin
            run_op(1'(s), 64'd84, 64'd0, lat, bcnt);
            total++; if (quotient !== '1)     begin bad++; $display("FAIL dz_q sgn=%0d: got %h want all ones", s, quotient); end
            total++; if (remainder !== 64'd84) begin bad++; $display("FAIL dz_r sgn=%0d: got %0d want 84", s, remainder); end
            total++; if (lat !== ZLAT)         begin bad++; $display("FAIL dz_latency sgn=%0d: got %0d want %0d", s, lat, ZLAT); end
        end
        run_op(1'b1, 64'hFFFF_FFFF_FFFF_FF00, 64'd0, lat, bcnt);
        total++; if (remainder !== 64'hFFFF_FFFF_FFFF_FF00) begin bad++; $display("FAIL dz_neg_r: got %h want ffffffffffffff00", remainder); end
    endtask

    task automatic test_overflow();
        int lat, bcnt;
        run_op(1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, lat, bcnt);
        total++; if (quotient !== 64'h8000_0000_0000_0000) begin bad++; $display("FAIL ovf_q: got %h want 8000000000000000", quotient); end
        total++; if (remainder !== 64'd0)                  begin bad++; $display("FAIL ovf_r: got %h want 0", remainder); end
    endtask

    task automatic test_abort_and_ignore();
        int lat, bcnt;
        sgn = 1'b0; dividend = 64'd120; divisor = 64'd29; L = 1'b1;
        @(posedge Clk); #1;
        L = 1'b0;
        repeat (29) @(posedge Clk);
        #1;
        Rst = 1'b0;
        #1;
        total++; if (quotient !== '0)  begin bad++; $display("FAIL abort_q: got %h want 0", quotient); end
        total++; if (remainder !== '0) begin bad++; $display("FAIL abort_r: got %h want 0", remainder); end
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0)    begin bad++; $display("FAIL abort_done: got %b want 0", done); end
        @(posedge Clk); #1;
        Rst = 1'b1;
        @(posedge Clk); #1;
        run_op(1'b0, 64'd30, 64'd29, lat, bcnt);
        total++; if (quotient !== 64'd1)  begin bad++; $display("FAIL after_abort_q: got %0d want 1", quotient); end
        total++; if (remainder !== 64'd1) begin bad++; $display("FAIL after_abort_r: got %0d want 1", remainder); end
        sgn = 1'b0; dividend = 64'd120; divisor = 64'd29; L = 1'b1;
        @(posedge Clk); #1;
        L = 1'b0;
        lat = 0;
        while (!done && lat < 200) begin
            L = (lat == 10);
            if (lat == 10) begin dividend = 64'd7; divisor = 64'd1; end
            @(posedge Clk); #1;
            lat++;
        end
        L = 1'b0;
        total++; if (lat !== LAT)         begin bad++; $display("FAIL ignore_latency: got %0d want %0d", lat, LAT); end
        total++; if (quotient !== 64'd4)  begin bad++; $display("FAIL ignore_q: got %0d want 4", quotient); end
        total++; if (remainder !== 64'd4) begin bad++; $display("FAIL ignore_r: got %0d want 4", remainder); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_back_to_back();
        test_hold_load();
        test_signed();
        test_div_zero();
        test_overflow();
        test_abort_and_ignore();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
